memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares one single-port word memory (combinational read, byte-enabled clocked write) between instruction fetch (IF) and the load/store unit (LSU).
- Arbitrates between the two requesters and drives the memory's enable, write, byte-enable, address and data ports.
- For the LSU, converts RV32I funct3 accesses into lane enables and replicated store data, and sign- or zero-extends loads.
- Returns registered responses one cycle after grant, with a fault flag for misaligned or illegal LSU accesses.

Parameters:
- ADRESS_SIZE, 32, width of all byte addresses.
- STARVE_LIMIT, 4, consecutive denied IF-request cycles after which IF is forced to win arbitration.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- IfReq  input  1  IF request; held with IfAdress until granted.
- IfAdress  input  ADRESS_SIZE  IF byte address; bits [1:0] ignored.
- IfReady  output  1  IF granted this cycle (combinational).
- IfValid  output  1  one-cycle pulse, IF response valid.
- IfData  output  32  fetched word.
- LsReq  input  1  LSU request; held with all Ls* inputs until granted.
- LsWrite  input  1  1 = store, 0 = load.
- LsFunct3  input  3  RV32I load/store funct3.
- LsAdress  input  ADRESS_SIZE  LSU byte address.
- LsWriteData  input  32  store data, right-aligned.
- LsReady  output  1  LSU granted this cycle (combinational).
- LsValid  output  1  one-cycle pulse, LSU response valid.
- LsData  output  32  extended load data; 0 for stores and faults.
- LsFault  output  1  qualifies LsValid; misaligned or illegal funct3.
- MemEn  output  1  memory enable.
- WriteEnable  output  1  memory write strobe.
- ByteEn  output  4  memory byte lanes.
- MemoryAdress  output  ADRESS_SIZE  word-aligned address, {addr[ADRESS_SIZE-1:2],2'b00}.
- InputData  output  32  lane-replicated store data.
- MemData  input  32  combinational read data from memory.

Behaviour:
- Reset (async, reset_n=0): IfValid, LsValid, LsFault = 0; IfData, LsData = 0; starvation counter = 0. Memory outputs are 0 whenever no grant is issued.
- Arbitration is combinational; at most one grant per cycle.
  - Only one requester active: it wins.
  - Both active: LSU wins unless starvation counter == STARVE_LIMIT, in which case IF wins.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on cycles with IfReq=1 and IfReady=0.
  - Clears on an IF grant or on any cycle with IfReq=0.
- Handshake:
  - A transaction is accepted on the rising edge where Req and Ready are both 1.
  - The requester may change its inputs after that edge.
  - Back-to-back grants every cycle are legal.
- IF grant: MemEn=1, WriteEnable=0, ByteEn=4'b0000. MemData is registered into IfData; IfValid=1 in the next cycle only.
- LSU legal load (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU):
  - MemEn=1, WriteEnable=0.
  - Lane select: byte lane = addr[1:0]; halfword lane = addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Result registered into LsData; LsValid=1 and LsFault=0 next cycle.
- LSU legal store (funct3 000 SB, 001 SH, 010 SW):
  - MemEn=1, WriteEnable=1.
  - ByteEn: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<(2*addr[1]); SW = 4'b1111.
  - InputData: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
  - Memory is written at the grant edge. Next cycle: LsValid=1, LsData=0, LsFault=0.
- LSU fault: halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 in {011, 110, 111}, or 100/101 with LsWrite=1.
  - Still granted and still consumes the slot (IF is not granted that cycle).
  - MemEn=0, WriteEnable=0, ByteEn=0; no memory access occurs.
  - Next cycle: LsValid=1, LsFault=1, LsData=0.
- Valid pulses last exactly one cycle. IfValid and LsValid are never both 1.
- Reset asserted mid-operation: a write granted on an earlier edge has already completed. A pending response is discarded; Valid does not pulse after reset deasserts.

Test Plan:
- IF only, memory word 0x00000100 = 0xDEADBEEF, IfReq with IfAdress=0x102 → IfReady=1, MemoryAdress=0x100; next cycle IfValid=1, IfData=0xDEADBEEF.
- LB at 0x101 and LBU at 0x101 on word 0x12AB8034 → LsData=0xFFFFFF80, then 0x00000080; each with LsValid=1, LsFault=0.
- SH LsWriteData=0x0000CAFE at 0x0C2 → ByteEn=1100, InputData=0xCAFECAFE, WriteEnable=1; a following LW at 0x0C0 returns 0xCAFE_xxxx with the low half unchanged.
- Both requesting continuously, STARVE_LIMIT=4 → grants L,L,L,L,I,L,L,L,L,I...; IfValid and LsValid never coincide.
- LW at 0x0C2, and funct3=011 → LsReady=1, MemEn=0, next cycle LsFault=1, LsData=0; IF is not granted in the faulting cycle.
- Drop reset_n low one cycle after an LW grant → LsValid stays 0, all outputs 0; normal operation resumes after reset_n returns to 1.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port word memory between IF and LSU.
// RV32I lane steering, load extension, registered responses with fault flag.
module memory_arbiter #(
  parameter int ADRESS_SIZE  = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   IfReq,
  input  logic [ADRESS_SIZE-1:0] IfAdress,
  output logic                   IfReady,
  output logic                   IfValid,
  output logic [31:0]            IfData,
  input  logic                   LsReq,
  input  logic                   LsWrite,
  input  logic [2:0]             LsFunct3,
  input  logic [ADRESS_SIZE-1:0] LsAdress,
  input  logic [31:0]            LsWriteData,
  output logic                   LsReady,
  output logic                   LsValid,
  output logic [31:0]            LsData,
  output logic                   LsFault,
  output logic                   MemEn,
  output logic                   WriteEnable,
  output logic [3:0]             ByteEn,
  output logic [ADRESS_SIZE-1:0] MemoryAdress,
  output logic [31:0]            InputData,
  input  logic [31:0]            MemData
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic          ls_size_b;
  logic          ls_size_h;
  logic          ls_size_w;
  logic          ls_unsigned;
  logic          ls_illegal;
  logic          ls_misaligned;
  logic          ls_fault;
  logic          ls_access;

  logic          if_grant;
  logic          ls_grant;

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;

  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  logic          if_valid_q;
  logic          if_valid_d;
  logic [31:0]   if_data_q;
  logic [31:0]   if_data_d;
  logic          ls_valid_q;
  logic          ls_valid_d;
  logic          ls_fault_q;
  logic          ls_fault_d;
  logic [31:0]   ls_data_q;
  logic [31:0]   ls_data_d;

  // IF fetches whole words; the byte offset is dropped.
  logic          unused_if_lsb;
  assign unused_if_lsb = ^IfAdress[1:0];

  // decode funct3 into access size, signedness and legality
  always_comb begin
    ls_size_b   = 1'b0;
    ls_size_h   = 1'b0;
    ls_size_w   = 1'b0;
    ls_unsigned = 1'b0;
    ls_illegal  = 1'b0;
    case (LsFunct3)
      F3_B: ls_size_b = 1'b1;
      F3_H: ls_size_h = 1'b1;
      F3_W: ls_size_w = 1'b1;
      F3_BU: begin
        ls_size_b   = 1'b1;
        ls_unsigned = 1'b1;
        ls_illegal  = LsWrite;
      end
      F3_HU: begin
        ls_size_h   = 1'b1;
        ls_unsigned = 1'b1;
        ls_illegal  = LsWrite;
      end
      default: ls_illegal = 1'b1;
    endcase
    ls_misaligned = (ls_size_h & LsAdress[0])
                  | (ls_size_w & (|LsAdress[1:0]));
    ls_fault      = ls_illegal | ls_misaligned;
  end

  // LSU has priority unless IF has been starved to the limit
  always_comb begin
    if_grant = IfReq & (~LsReq | (starve_q == STARVE_MAX));
    ls_grant = LsReq & ~if_grant;
  end

  assign IfReady = if_grant;
  assign LsReady = ls_grant;

  // count consecutive denied IF cycles, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!IfReq || if_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // store lane enables and replicated write data
  always_comb begin
    st_be   = 4'b1111;
    st_data = LsWriteData;
    unique case (1'b1)
      ls_size_b: begin
        st_be   = 4'b0001 << LsAdress[1:0];
        st_data = {4{LsWriteData[7:0]}};
      end
      ls_size_h: begin
        st_be   = LsAdress[1] ? 4'b1100 : 4'b0011;
        st_data = {2{LsWriteData[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = LsWriteData;
      end
    endcase
  end

  // select the addressed lane of the read word and extend it
  always_comb begin
    case (LsAdress[1:0])
      2'd0:    ld_byte = MemData[7:0];
      2'd1:    ld_byte = MemData[15:8];
      2'd2:    ld_byte = MemData[23:16];
      default: ld_byte = MemData[31:24];
    endcase
    ld_half = LsAdress[1] ? MemData[31:16] : MemData[15:0];
    ld_ext  = MemData;
    unique case (1'b1)
      ls_size_b: ld_ext = {{24{~ls_unsigned & ld_byte[7]}}, ld_byte};
      ls_size_h: ld_ext = {{16{~ls_unsigned & ld_half[15]}}, ld_half};
      default:   ld_ext = MemData;
    endcase
  end

  assign ls_access = ls_grant & ~ls_fault;

  // drive the memory port; everything idles at zero without an access
  always_comb begin
    MemEn        = 1'b0;
    WriteEnable  = 1'b0;
    ByteEn       = 4'b0000;
    MemoryAdress = '0;
    InputData    = '0;
    if (if_grant) begin
      MemEn        = 1'b1;
      MemoryAdress = {IfAdress[ADRESS_SIZE-1:2], 2'b00};
    end else if (ls_access) begin
      MemEn        = 1'b1;
      MemoryAdress = {LsAdress[ADRESS_SIZE-1:2], 2'b00};
      if (LsWrite) begin
        WriteEnable = 1'b1;
        ByteEn      = st_be;
        InputData   = st_data;
      end
    end
  end

  // capture responses for the cycle after the grant
  always_comb begin
    if_valid_d = if_grant;
    if_data_d  = if_grant ? MemData : if_data_q;
    ls_valid_d = ls_grant;
    ls_fault_d = ls_grant & ls_fault;
    ls_data_d  = ls_data_q;
    if (ls_grant) begin
      ls_data_d = (ls_fault || LsWrite) ? 32'd0 : ld_ext;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q   <= '0;
      if_valid_q <= 1'b0;
      if_data_q  <= '0;
      ls_valid_q <= 1'b0;
      ls_fault_q <= 1'b0;
      ls_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      if_valid_q <= if_valid_d;
      if_data_q  <= if_data_d;
      ls_valid_q <= ls_valid_d;
      ls_fault_q <= ls_fault_d;
      ls_data_q  <= ls_data_d;
    end
  end

  assign IfValid = if_valid_q;
  assign IfData  = if_data_q;
  assign LsValid = ls_valid_q;
  assign LsFault = ls_fault_q;
  assign LsData  = ls_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic
// checked against a byte-level memory and arbitration model.
module tb_memory_arbiter;
  localparam int AS  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          IfReq;
  logic [AS-1:0] IfAdress;
  logic          IfReady;
  logic          IfValid;
  logic [31:0]   IfData;
  logic          LsReq;
  logic          LsWrite;
  logic [2:0]    LsFunct3;
  logic [AS-1:0] LsAdress;
  logic [31:0]   LsWriteData;
  logic          LsReady;
  logic          LsValid;
  logic [31:0]   LsData;
  logic          LsFault;
  logic          MemEn;
  logic          WriteEnable;
  logic [3:0]    ByteEn;
  logic [AS-1:0] MemoryAdress;
  logic [31:0]   InputData;
  logic [31:0]   MemData;

  logic [31:0] mem [0:255];
  logic [7:0]  rb  [0:1023];
  logic        bd_en = 1'b0;
  logic [7:0]  bd_a;
  logic [31:0] bd_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADRESS_SIZE(AS), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .IfReq(IfReq), .IfAdress(IfAdress), .IfReady(IfReady),
    .IfValid(IfValid), .IfData(IfData),
    .LsReq(LsReq), .LsWrite(LsWrite), .LsFunct3(LsFunct3),
    .LsAdress(LsAdress), .LsWriteData(LsWriteData),
    .LsReady(LsReady), .LsValid(LsValid), .LsData(LsData),
    .LsFault(LsFault), .MemEn(MemEn), .WriteEnable(WriteEnable),
    .ByteEn(ByteEn), .MemoryAdress(MemoryAdress),
    .InputData(InputData), .MemData(MemData)
  );

  assign MemData = mem[MemoryAdress[9:2]];

  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_a] <= bd_w;
    end else if (MemEn && WriteEnable) begin
      for (int k = 0; k < 4; k++)
        if (ByteEn[k]) mem[MemoryAdress[9:2]][8*k +: 8] <= InputData[8*k +: 8];
    end
  end

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    bd_en = 1'b1;
    bd_a  = a[9:2];
    bd_w  = w;
    for (int i = 0; i < 4; i++) rb[{a[9:2], 2'b00} + i] = w[8*i +: 8];
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask

  task automatic idle();
    IfReq = 1'b0;
    LsReq = 1'b0;
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit exp_fault(input logic w, input logic [2:0] f3,
                                   input logic [31:0] a);
    int sz;
    if (f3[1:0] == 2'd3) return 1'b1;
    if (f3[2] && (w || f3[1])) return 1'b1;
    sz = acc_size(f3);
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = acc_size(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v = v | (32'(rb[a[9:0] + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    LsWrite = 0; LsFunct3 = 0; LsAdress = 0; LsWriteData = 0; IfAdress = 0;
    for (int i = 0; i < 256; i++) set_word(i * 4, $urandom);
    @(negedge clk); #1;
    if ({IfValid, LsValid, LsFault} !== 3'b000) begin
      fails++;
      $display("FAIL reset_valid got=%b exp=000", {IfValid, LsValid, LsFault});
    end
    tests++;
    if (IfData !== 32'd0 || LsData !== 32'd0) begin
      fails++;
      $display("FAIL reset_data got=%h/%h exp=0/0", IfData, LsData);
    end
    tests++;
    if ({MemEn, WriteEnable, ByteEn, IfReady, LsReady} !== 8'd0) begin
      fails++;
      $display("FAIL reset_mem got=%b exp=0",
               {MemEn, WriteEnable, ByteEn, IfReady, LsReady});
    end
    tests++;
    if (MemoryAdress !== 32'd0 || InputData !== 32'd0) begin
      fails++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", MemoryAdress, InputData);
    end
    tests++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_fetch();
    set_word(32'h100, 32'hDEADBEEF);
    @(negedge clk);
    IfReq = 1'b1; IfAdress = 32'h102;
    #1;
    if (IfReady !== 1'b1 || LsReady !== 1'b0) begin
      fails++;
      $display("FAIL if_ready got=%b%b exp=10", IfReady, LsReady);
    end
    tests++;
    if (MemoryAdress !== 32'h100 || {MemEn, WriteEnable, ByteEn} !== 6'b100000) begin
      fails++;
      $display("FAIL if_mem got=%h %b exp=100 100000",
               MemoryAdress, {MemEn, WriteEnable, ByteEn});
    end
    tests++;
    @(posedge clk); #1;
    IfReq = 1'b0;
    if (IfValid !== 1'b1 || IfData !== 32'hDEADBEEF || LsValid !== 1'b0) begin
      fails++;
      $display("FAIL if_resp got=%b %h %b exp=1 deadbeef 0", IfValid, IfData, LsValid);
    end
    tests++;
    @(posedge clk); #1;
    if (IfValid !== 1'b0) begin
      fails++;
      $display("FAIL if_pulse got=%b exp=0", IfValid);
    end
    tests++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [2];
    logic [31:0] exps [2];
    f3s[0] = 3'b000; exps[0] = 32'hFFFFFF80;
    f3s[1] = 3'b100; exps[1] = 32'h00000080;
    set_word(32'h100, 32'h12AB8034);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      LsReq = 1'b1; LsWrite = 1'b0; LsFunct3 = f3s[i]; LsAdress = 32'h101;
      #1;
      if (LsReady !== 1'b1 || {MemEn, WriteEnable} !== 2'b10) begin
        fails++;
        $display("FAIL ld_grant%0d got=%b %b exp=1 10", i, LsReady, {MemEn, WriteEnable});
      end
      tests++;
      @(posedge clk); #1;
      LsReq = 1'b0;
      if (LsValid !== 1'b1 || LsFault !== 1'b0 || LsData !== exps[i]) begin
        fails++;
        $display("FAIL ld_ext%0d got=%b %b %h exp=1 0 %h",
                 i, LsValid, LsFault, LsData, exps[i]);
      end
      tests++;
    end
  endtask

  task automatic test_store_sh();
    set_word(32'h0C0, 32'h5555_1234);
    @(negedge clk);
    LsReq = 1'b1; LsWrite = 1'b1; LsFunct3 = 3'b001;
    LsAdress = 32'h0C2; LsWriteData = 32'h0000CAFE;
    #1;
    if (ByteEn !== 4'b1100 || InputData !== 32'hCAFECAFE ||
        {MemEn, WriteEnable} !== 2'b11 || MemoryAdress !== 32'h0C0) begin
      fails++;
      $display("FAIL sh_port got=%b %h %b %h exp=1100 cafecafe 11 0c0",
               ByteEn, InputData, {MemEn, WriteEnable}, MemoryAdress);
    end
    tests++;
    rb[10'h0C2] = 8'hFE;
    rb[10'h0C3] = 8'hCA;
    @(posedge clk); #1;
    LsWrite = 1'b0; LsFunct3 = 3'b010; LsAdress = 32'h0C0;
    if (LsValid !== 1'b1 || LsData !== 32'd0 || LsFault !== 1'b0) begin
      fails++;
      $display("FAIL sh_resp got=%b %h %b exp=1 0 0", LsValid, LsData, LsFault);
    end
    tests++;
    @(posedge clk); #1;
    LsReq = 1'b0;
    if (LsValid !== 1'b1 || LsData !== 32'hCAFE1234) begin
      fails++;
      $display("FAIL sh_readback got=%b %h exp=1 cafe1234", LsValid, LsData);
    end
    tests++;
  endtask

  task automatic test_starvation();
    bit exp_if;
    bit prev_if = 0;
    @(negedge clk);
    IfReq = 1'b1; IfAdress = 32'h200;
    LsReq = 1'b1; LsWrite = 1'b0; LsFunct3 = 3'b010; LsAdress = 32'h204;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_if = (i % 5) == 4;
      if (IfReady !== exp_if || LsReady !== !exp_if) begin
        fails++;
        $display("FAIL starve_c%0d got=%b%b exp=%b%b", i, IfReady, LsReady, exp_if, !exp_if);
      end
      tests++;
      @(posedge clk); #1;
      if ((IfValid && LsValid) || IfValid !== exp_if) begin
        fails++;
        $display("FAIL starve_v%0d got=%b%b exp=%b%b", i, IfValid, LsValid, exp_if, !exp_if);
      end
      tests++;
      prev_if = exp_if;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_faults();
    logic        ws  [6];
    logic [2:0]  fs  [6];
    logic [31:0] as_ [6];
    ws[0] = 0; fs[0] = 3'b010; as_[0] = 32'h0C2;
    ws[1] = 0; fs[1] = 3'b011; as_[1] = 32'h0C0;
    ws[2] = 1; fs[2] = 3'b100; as_[2] = 32'h0C0;
    ws[3] = 0; fs[3] = 3'b001; as_[3] = 32'h0C1;
    ws[4] = 1; fs[4] = 3'b111; as_[4] = 32'h0C0;
    ws[5] = 1; fs[5] = 3'b010; as_[5] = 32'h0C1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      IfReq = 1'b1; IfAdress = 32'h100;
      LsReq = 1'b1; LsWrite = ws[i]; LsFunct3 = fs[i];
      LsAdress = as_[i]; LsWriteData = 32'h11223344;
      #1;
      if ({LsReady, IfReady, MemEn, WriteEnable, ByteEn} !== 8'b1000_0000) begin
        fails++;
        $display("FAIL flt_port%0d got=%b exp=10000000", i,
                 {LsReady, IfReady, MemEn, WriteEnable, ByteEn});
      end
      tests++;
      @(posedge clk); #1;
      idle();
      if ({LsValid, LsFault, IfValid} !== 3'b110 || LsData !== 32'd0) begin
        fails++;
        $display("FAIL flt_resp%0d got=%b %h exp=110 0", i,
                 {LsValid, LsFault, IfValid}, LsData);
      end
      tests++;
      @(posedge clk); #1;
    end
    if (mem[8'h30] !== ref_word(32'h0C0)) begin
      fails++;
      $display("FAIL flt_nowrite got=%h exp=%h", mem[8'h30], ref_word(32'h0C0));
    end
    tests++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    LsReq = 1'b1; LsWrite = 1'b1; LsFunct3 = 3'b010;
    LsAdress = 32'h180; LsWriteData = 32'h0A5A5A5A;
    for (int i = 0; i < 4; i++) rb[10'h180 + i] = LsWriteData[8*i +: 8];
    @(posedge clk); #1;
    LsWrite = 1'b0; LsAdress = 32'h100;
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle();
    #1;
    if ({LsValid, LsFault, IfValid, MemEn} !== 4'b0 || LsData !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_clear got=%b %h exp=0000 0",
               {LsValid, LsFault, IfValid, MemEn}, LsData);
    end
    tests++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (LsValid !== 1'b0 || IfValid !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_nopulse%0d got=%b%b exp=00", i, LsValid, IfValid);
      end
      tests++;
    end
    @(negedge clk);
    LsReq = 1'b1; LsWrite = 1'b0; LsFunct3 = 3'b010; LsAdress = 32'h180;
    @(posedge clk); #1;
    idle();
    if (LsValid !== 1'b1 || LsData !== 32'h0A5A5A5A) begin
      fails++;
      $display("FAIL rstmid_resume got=%b %h exp=1 0a5a5a5a", LsValid, LsData);
    end
    tests++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          if_p = 0, ls_p = 0, gi, gl, flt;
    logic [31:0] if_a = 0, ls_a = 0, ls_d = 0, ea, ed, ifd, lsd;
    logic        ls_w = 0, een, ewe;
    logic [2:0]  ls_f = 0;
    logic [3:0]  ebe;
    int          denied = 0, sz, bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!if_p && $urandom_range(0, 99) < 60) begin
        if_p = 1; if_a = $urandom & 32'h3FF;
      end
      if (!ls_p && $urandom_range(0, 99) < 60) begin
        ls_p = 1; ls_w = 1'($urandom_range(0, 1));
        ls_f = 3'($urandom_range(0, 7)); ls_a = $urandom & 32'h3FF;
        ls_d = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (ls_f[1:0] == 2'd2) ls_a[1:0] = 2'b00;
          if (ls_f[1:0] == 2'd1) ls_a[0] = 1'b0;
        end
      end
      IfReq = if_p; IfAdress = if_a;
      LsReq = ls_p; LsWrite = ls_w; LsFunct3 = ls_f;
      LsAdress = ls_a; LsWriteData = ls_d;
      #1;
      gi = if_p && (!ls_p || denied == LIM);
      gl = ls_p && !gi;
      if (IfReady !== gi || LsReady !== gl) begin
        fails++;
        $display("FAIL rnd_grant c%0d got=%b%b exp=%b%b", c, IfReady, LsReady, gi, gl);
      end
      tests++;
      een = 0; ewe = 0; ebe = 0; ea = 0; ed = 0; flt = 0; ifd = 0; lsd = 0;
      if (gi) begin
        een = 1; ea = {if_a[31:2], 2'b00}; ifd = ref_word(if_a);
      end
      if (gl) begin
        flt = exp_fault(ls_w, ls_f, ls_a);
        if (!flt) begin
          een = 1; ea = {ls_a[31:2], 2'b00};
          sz = acc_size(ls_f);
          if (ls_w) begin
            ewe = 1;
            ebe = 4'(((1 << sz) - 1) << ls_a[1:0]);
            ed  = (sz == 1) ? ls_d[7:0] * 32'h01010101 :
                  (sz == 2) ? ls_d[15:0] * 32'h00010001 : ls_d;
            for (int i = 0; i < sz; i++) rb[ls_a[9:0] + i] = ls_d[8*i +: 8];
          end else begin
            lsd = exp_load(ls_f, ls_a);
          end
        end
      end
      if ({MemEn, WriteEnable, ByteEn} !== {een, ewe, ebe} ||
          ((een || !(gi || gl)) && MemoryAdress !== ea) ||
          (ewe && InputData !== ed)) begin
        fails++;
        $display("FAIL rnd_port c%0d got=%b %h %h exp=%b %h %h", c,
                 {MemEn, WriteEnable, ByteEn}, MemoryAdress, InputData,
                 {een, ewe, ebe}, ea, ed);
      end
      tests++;
      denied = (!if_p || gi) ? 0 : (denied < LIM ? denied + 1 : LIM);
      @(posedge clk); #1;
      if (IfValid !== gi || LsValid !== gl || (gi && IfData !== ifd) ||
          (gl && (LsFault !== flt || LsData !== lsd))) begin
        fails++;
        $display("FAIL rnd_resp c%0d got=%b%b %h %b %h exp=%b%b %h %b %h", c,
                 IfValid, LsValid, IfData, LsFault, LsData,
                 gi, gl, ifd, flt, lsd);
      end
      tests++;
      if (gi) if_p = 0;
      if (gl) ls_p = 0;
    end
    idle();
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_word(i * 4)) bad++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rnd_memimage got=%0d bad words exp=0", bad);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_load_ext();
    test_store_sh();
    test_starvation();
    test_faults();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
